// File: rtl/bus_xbar_rr_pkg.sv
// Shared defaults and arbiter state encoding for the bus_xbar_rr interconnect.
// No logic of its own; the one-hot helper is purely combinational.
// No flow control here; consumers decide how these types are used.
package bus_xbar_rr_pkg;

  localparam int BUS_ADDR_W     = 30;
  localparam int BUS_DATA_W     = 32;
  localparam int BUS_SEL_W      = 3;
  localparam int BUS_TIMEOUT    = 255;
  localparam int BUS_MAX_MASTER = 8;

  typedef enum logic {
    BUS_ST_IDLE  = 1'b0,
    BUS_ST_OWNED = 1'b1
  } bus_st_e;

  // One-hot (or zero) to binary index; OR-reduction keeps it a flat mux tree.
  function automatic logic [2:0] bus_oh2idx(input logic [BUS_MAX_MASTER-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < BUS_MAX_MASTER; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_xbar_rr_arbiter.sv
// Round-robin bus arbiter; ownership is held while the owner keeps requesting.
// Latency: req in cycle n gives grnt in cycle n+1; release moves/clears grnt in n+1.
// Backpressure: requesters simply wait with req high until granted.
module bus_rr_arbiter
  import bus_xbar_rr_pkg::*;
#(
  parameter int N_MASTER = 4
) (
  input  logic                clk,
  input  logic                rest,
  input  logic [N_MASTER-1:0] req,
  output logic [N_MASTER-1:0] grnt
);

  localparam int                IDX_W    = $clog2(N_MASTER);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_MASTER - 1);

  bus_st_e          state;
  logic [IDX_W-1:0] last;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  // Find the first requester after the last owner, wrapping around; the last
  // owner itself is checked last so a just-released master loses to others.
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = last;
    j        = 0;
    jj       = '0;
    for (int k = 1; k <= N_MASTER; k++) begin
      j = int'(last) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      jj = IDX_W'(j);
      if (!pick_vld && req[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  // Grant FSM: grab in IDLE, hold while owner requests, hand over on release.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= BUS_ST_IDLE;
      last  <= LAST_RST;
      grnt  <= '0;
    end else begin
      case (state)
        BUS_ST_IDLE: begin
          if (pick_vld) begin
            state <= BUS_ST_OWNED;
            last  <= pick_idx;
            grnt  <= N_MASTER'(1) << pick_idx;
          end
        end
        BUS_ST_OWNED: begin
          if (!req[last]) begin
            if (pick_vld) begin
              last <= pick_idx;
              grnt <= N_MASTER'(1) << pick_idx;
            end else begin
              state <= BUS_ST_IDLE;
              grnt  <= '0;
            end
          end
        end
        default: begin
          state <= BUS_ST_IDLE;
          grnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_xbar_rr.sv
// Shared-bus interconnect: N masters, N slaves, round-robin ownership, address decode.
// Latency: grant is registered (1 cycle); address, decode and read paths are combinational.
// Backpressure: masters stall until bus_rdy; BUS_TIMEOUT_EN adds a timeout error for silent slaves.
module bus_xbar_rr
  import bus_xbar_rr_pkg::*;
#(
  parameter int N_MASTER = 4,
  parameter int N_SLAVE  = 8,
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int SEL_W    = BUS_SEL_W,
  parameter int TIMEOUT  = BUS_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic [N_MASTER-1:0]        bus_m_req,
  input  logic [N_MASTER*ADDR_W-1:0] bus_m_addr,
  input  logic [N_MASTER-1:0]        bus_m_as,
  input  logic [N_MASTER-1:0]        bus_m_rw,
  input  logic [N_MASTER*DATA_W-1:0] bus_m_wr_data,
  output logic [N_MASTER-1:0]        bus_m_grnt,
  output logic [ADDR_W-1:0]          bus_s_addr,
  output logic                       bus_s_as,
  output logic                       bus_s_rw,
  output logic [DATA_W-1:0]          bus_s_wr_data,
  output logic [N_SLAVE-1:0]         bus_s_cs,
  input  logic [N_SLAVE*DATA_W-1:0]  bus_s_rd_data,
  input  logic [N_SLAVE-1:0]         bus_s_rdy,
  output logic [DATA_W-1:0]          bus_rd_data,
  output logic                       bus_rdy,
  output logic                       bus_err
);

  localparam int MIDX_W = $clog2(N_MASTER);

  logic              owned;
  logic [MIDX_W-1:0] oidx;
  logic [SEL_W-1:0]  sel;
  logic              mapped;
  logic              slv_rdy;
  logic [DATA_W-1:0] slv_data;
  logic              unmap_err;
  logic              to_fire;

  bus_rr_arbiter #(
    .N_MASTER (N_MASTER)
  ) u_arb (
    .clk  (clk),
    .rest (rest),
    .req  (bus_m_req),
    .grnt (bus_m_grnt)
  );

  assign owned = |bus_m_grnt;
  assign oidx  = MIDX_W'(bus_oh2idx(BUS_MAX_MASTER'(bus_m_grnt)));

  // Broadcast the owner's request to all slaves; an idle bus drives zeros.
  always_comb begin
    bus_s_addr    = '0;
    bus_s_as      = 1'b0;
    bus_s_rw      = 1'b0;
    bus_s_wr_data = '0;
    if (owned) begin
      bus_s_addr    = bus_m_addr[int'(oidx)*ADDR_W +: ADDR_W];
      bus_s_as      = bus_m_as[oidx];
      bus_s_rw      = bus_m_rw[oidx];
      bus_s_wr_data = bus_m_wr_data[int'(oidx)*DATA_W +: DATA_W];
    end
  end

  assign sel    = bus_s_addr[ADDR_W-1 -: SEL_W];
  assign mapped = (int'(sel) < N_SLAVE);

  // Decode the top address bits into a one-hot chip select.
  always_comb begin
    bus_s_cs = '0;
    if (owned && mapped) begin
      for (int i = 0; i < N_SLAVE; i++) begin
        if (int'(sel) == i) bus_s_cs[i] = 1'b1;
      end
    end
  end

  // Return path from whichever slave is selected.
  always_comb begin
    slv_rdy  = 1'b0;
    slv_data = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (bus_s_cs[i]) begin
        slv_rdy  = bus_s_rdy[i];
        slv_data = bus_s_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A strobe to a hole in the map completes immediately with an error.
  assign unmap_err = owned && !mapped && bus_s_as;

  // Final response: timeout beats everything, then unmapped, then the slave.
  always_comb begin
    bus_rdy     = slv_rdy;
    bus_err     = 1'b0;
    bus_rd_data = slv_data;
    if (to_fire || unmap_err) begin
      bus_rdy     = 1'b1;
      bus_err     = 1'b1;
      bus_rd_data = '0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT);

  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic             own_chg;

  // Owner dropping req always moves or clears the grant at the next edge.
  assign own_chg = owned && !bus_m_req[oidx];
  // The counter stands at TIMEOUT exactly TIMEOUT cycles after the strobe.
  assign to_fire = pend && (cnt == CNT_TOP);

  // Track an unanswered strobe and count how long it has been waiting.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (bus_rdy || own_chg) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (pend || bus_s_as) begin
      pend <= 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Self-checking bench for bus_xbar_rr: directed scenarios plus random traffic.
// Expected values come from a transaction-level model of ownership and decode.
// Outputs are sampled away from the rising edge.
module tb_bus_xbar_rr;

  localparam int NM = 4;
  localparam int NS = 6;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rest;
  logic [NM-1:0]     m_req, m_as, m_rw;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wd;
  logic [NM-1:0]     grnt;
  logic [AW-1:0]     s_addr;
  logic              s_as, s_rw;
  logic [DW-1:0]     s_wd;
  logic [NS-1:0]     s_cs;
  logic [NS*DW-1:0]  s_rd;
  logic [NS-1:0]     s_rdy;
  logic [DW-1:0]     rd;
  logic              rdy, err;

  always #5 clk = ~clk;

  bus_xbar_rr #(
    .N_MASTER (NM), .N_SLAVE (NS), .ADDR_W (AW),
    .DATA_W (DW), .SEL_W (SW), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rest (rest),
    .bus_m_req (m_req), .bus_m_addr (m_addr), .bus_m_as (m_as),
    .bus_m_rw (m_rw), .bus_m_wr_data (m_wd), .bus_m_grnt (grnt),
    .bus_s_addr (s_addr), .bus_s_as (s_as), .bus_s_rw (s_rw),
    .bus_s_wr_data (s_wd), .bus_s_cs (s_cs), .bus_s_rd_data (s_rd),
    .bus_s_rdy (s_rdy), .bus_rd_data (rd), .bus_rdy (rdy), .bus_err (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current owner (-1 = none), last owner, cycle of unanswered strobe
  int   own, last, pend_since, cyc;
  logic x_rdy, x_as;

  task automatic model_reset();
    own = -1; last = NM - 1; pend_since = -1; cyc = 0;
  endtask

  task automatic check_outputs();
    logic [NM-1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, erd;
    logic [NS-1:0] ecs;
    logic          eas, erw, erdy, eerr, fire;
    int            idx;
    eg = '0; ea = '0; ewd = '0; erd = '0; ecs = '0;
    eas = 1'b0; erw = 1'b0; erdy = 1'b0; eerr = 1'b0; fire = 1'b0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      ea  = m_addr[own*AW +: AW];
      eas = m_as[own];
      erw = m_rw[own];
      ewd = m_wd[own*DW +: DW];
    end
    idx = int'(ea[AW-1 -: SW]);
`ifdef BUS_TIMEOUT_EN
    fire = (pend_since >= 0) && (cyc - pend_since == TO);
`endif
    if (own >= 0 && idx < NS) ecs[idx] = 1'b1;
    if (fire) begin
      erdy = 1'b1; eerr = 1'b1;
    end else if (own >= 0 && idx < NS) begin
      erdy = s_rdy[idx]; erd = s_rd[idx*DW +: DW];
    end else if (own >= 0 && eas) begin
      erdy = 1'b1; eerr = 1'b1;
    end
    chk("grnt", grnt, eg);
    chk("s_addr", s_addr, ea);
    chk("s_as", s_as, eas);
    chk("s_rw", s_rw, erw);
    chk("s_wr_data", s_wd, ewd);
    chk("s_cs", s_cs, ecs);
    chk("rdy", rdy, erdy);
    chk("err", err, eerr);
    chk("rd_data", rd, erd);
    x_rdy = erdy;
    x_as  = eas;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int nxt;
    if (x_rdy || (own >= 0 && !m_req[own])) pend_since = -1;
    else if (pend_since < 0 && x_as) pend_since = cyc;
    if (own < 0 || !m_req[own]) begin
      nxt = -1;
      for (int k = 1; k <= NM; k++) begin
        if (nxt < 0 && m_req[(last + k) % NM]) nxt = (last + k) % NM;
      end
      own = nxt;
      if (nxt >= 0) last = nxt;
    end
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic as_v, input logic rw_v);
    m_addr[i*AW +: AW] = a;
    m_as[i] = as_v;
    m_rw[i] = rw_v;
  endtask

  function automatic logic [AW-1:0] addr_of(input int idx, input logic [AW-1:0] low);
    logic [AW-1:0] a;
    a = low;
    a[AW-1 -: SW] = SW'(idx);
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a1;
    rest = 1'b0;
    m_req = '0; m_as = '0; m_rw = '0; m_addr = '0; m_wd = '0;
    s_rd = '0; s_rdy = '0;
    model_reset();
    x_rdy = 1'b0; x_as = 1'b0;
    #12;
    chk("rst_grnt", grnt, 0);
    chk("rst_cs", s_cs, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", s_addr, 0);
    rest = 1'b1;
    @(posedge clk); #1;

    // Fairness rotation with everyone requesting
    m_req = 4'b1111; run_cycle(); chk("rr0", grnt, 4'b0001);
    m_req = 4'b1110; run_cycle(); chk("rr1", grnt, 4'b0010);
    m_req = 4'b1101; run_cycle(); chk("rr2", grnt, 4'b0100);
    m_req = 4'b1011; run_cycle(); chk("rr3", grnt, 4'b1000);
    m_req = 4'b0111; run_cycle(); chk("rr_wrap", grnt, 4'b0001);
    m_req = 4'b0000; run_cycle(); run_cycle();

    // Read from slave 2, ready two cycles after the strobe
    set_master(2, addr_of(2, '0), 1'b1, 1'b1);
    m_req = 4'b0100; run_cycle();
    chk("rd_cs", s_cs, 6'b000100);
    run_cycle(); run_cycle();
    s_rd[2*DW +: DW] = 32'hDEAD_BEEF; s_rdy[2] = 1'b1; #1;
    chk("rd_rdy", rdy, 1); chk("rd_data_beef", rd, 32'hDEADBEEF); chk("rd_err", err, 0);
    run_cycle();
    m_req = '0; m_as = '0; s_rdy = '0; run_cycle();

    // Unmapped slave index 7
    set_master(0, addr_of(7, 30'h123), 1'b1, 1'b0);
    m_req = 4'b0001; run_cycle();
    chk("um_cs", s_cs, 0); chk("um_rdy", rdy, 1); chk("um_err", err, 1); chk("um_data", rd, 0);
    run_cycle();
    m_req = '0; m_as = '0; run_cycle();

    // Silent slave 3
    set_master(3, addr_of(3, 30'h40), 1'b1, 1'b1);
    m_req = 4'b1000; run_cycle();
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      chk("to_quiet", rdy, 0);
      run_cycle();
    end
    chk("to_rdy", rdy, 1); chk("to_err", err, 1); chk("to_data", rd, 0);
    m_req = '0; m_as = '0; run_cycle();
    chk("to_after_rdy", rdy, 0); chk("to_after_grnt", grnt, 0);
`else
    for (int k = 0; k < 100; k++) begin
      chk("stall_rdy", rdy, 0);
      run_cycle();
    end
    m_req = '0; m_as = '0; run_cycle();
`endif

    // Master 1 holds ownership against master 0
    a1 = addr_of(1, 30'h55);
    set_master(1, a1, 1'b0, 1'b0);
    m_req = 4'b0010; run_cycle();
    set_master(0, addr_of(5, 30'h77), 1'b1, 1'b1);
    m_req = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      run_cycle();
      chk("hold_grnt", grnt, 4'b0010);
      chk("hold_addr", s_addr, a1);
      chk("hold_as", s_as, 0);
    end
    m_req = '0; m_as = '0; run_cycle(); run_cycle();

    // Reset in the middle of a waiting transfer
    set_master(3, addr_of(3, 30'h9), 1'b1, 1'b0);
    m_req = 4'b1000; run_cycle();
    for (int k = 0; k < 10; k++) run_cycle();
    #2 rest = 1'b0;
    #1;
    chk("arst_grnt", grnt, 0); chk("arst_rdy", rdy, 0); chk("arst_err", err, 0);
    chk("arst_cs", s_cs, 0); chk("arst_as", s_as, 0);
    m_req = '0; m_as = '0;
    model_reset();
    @(negedge clk); rest = 1'b1;
    @(posedge clk); #1;
    set_master(2, addr_of(3, 30'h3), 1'b1, 1'b1);
    m_req = 4'b0100; run_cycle();
    for (int k = 0; k < 12; k++) begin
      chk("post_rst_err", err, 0);
      run_cycle();
    end
    m_req = '0; m_as = '0; run_cycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      m_req = m_req ^ NM'($urandom_range(0, 15) & $urandom_range(0, 15));
      m_as  = NM'($urandom);
      m_rw  = NM'($urandom);
      for (int i = 0; i < NM; i++) begin
        m_addr[i*AW +: AW] = AW'($urandom);
        m_wd[i*DW +: DW]   = $urandom;
      end
      for (int i = 0; i < NS; i++) s_rd[i*DW +: DW] = $urandom;
      s_rdy = NS'($urandom & $urandom);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
